picc_frame_decoder: RTL

- Reader-side (PCD) receiver stage directly downstream of the PICC load-modulation transmitter path.
- Consumes a stream of envelope amplitude samples over AXI-Stream and slices them against a threshold.
- Decodes ISO 14443-A card-to-reader Manchester bits (SOF, data+odd parity, EOF) and emits decoded bytes as AXI-Stream beats.
- The frame's last beat carries tlast.

---
 rtl/picc_frame_decoder.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/picc_frame_decoder.sv
// ISO 14443-A card-to-reader receiver: slices envelope samples against a threshold,
// decodes Manchester bits (SOF, data+parity, EOF) and emits one AXI-Stream beat per byte.
module picc_frame_decoder #(
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int SAMPLES_PER_BIT        = 8
) (
   input  logic                                s00_axis_aclk,
   input  logic                                s00_axis_aresetn,
   input  logic                                s00_axis_tvalid,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic                                s00_axis_tlast,
   output logic                                s00_axis_tready,
   output logic                                m00_axis_tvalid,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
   output logic                                m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
   input  logic                                m00_axis_tready,
   input  logic [15:0]                         threshold_in,
   output logic                                frame_active_out
);

   localparam int H   = SAMPLES_PER_BIT / 2;
   localparam int SCW = $clog2(SAMPLES_PER_BIT);
   localparam int HCW = $clog2(H + 1);
   localparam int RW  = 15;

   localparam logic [SCW-1:0] C_LAST_SAMP = SCW'(SAMPLES_PER_BIT - 1);
   localparam logic [SCW-1:0] C_HALF      = SCW'(H);
   localparam logic [HCW-1:0] C_HIGH_THR  = HCW'(H / 2);

   typedef enum logic [1:0] {IDLE, SOF, DATA, FLUSH} state_t;

   state_t         r_state, w_nextState;
   logic [SCW-1:0] r_sampCnt, w_nextSampCnt;
   logic [HCW-1:0] r_cntFirst, w_nextCntFirst;
   logic [HCW-1:0] r_cntSecond, w_nextCntSecond;
   logic [7:0]     r_shift, w_nextShift;
   logic [3:0]     r_bitCnt, w_nextBitCnt;
   logic           r_coll, w_nextColl;
   logic           r_holdValid, w_nextHoldValid;
   logic [RW-1:0]  r_holdRec, w_nextHoldRec;
   logic           r_mValid, w_nextMValid;
   logic [RW-1:0]  r_mData, w_nextMData;
   logic           r_mLast, w_nextMLast;
   logic           r_frameActive, w_nextFrameActive;

   logic [15:0]    w_sample;
   logic [15:0]    w_mag;
   logic           w_mod;
   logic           w_outFree;
   logic           w_sReady;
   logic           w_accept;
   logic           w_inFirst;
   logic           w_inSecond;
   logic           w_modFirst;
   logic           w_modSecond;
   logic           w_lastSamp;
   logic [HCW-1:0] w_cntFirst;
   logic [HCW-1:0] w_cntSecond;
   logic [SCW-1:0] w_stepSampCnt;
   logic [HCW-1:0] w_stepCntFirst;
   logic [HCW-1:0] w_stepCntSecond;
   logic           w_firstHigh;
   logic           w_secondHigh;
   logic           w_isEof;
   logic           w_isColl;
   logic           w_bit;
   logic [RW-1:0]  w_byteRec;
   logic [RW-1:0]  w_partRec;
   logic           w_unused;

   // Magnitude of the signed envelope sample; -32768 saturates so it still fits 15 bits.
   assign w_sample = s00_axis_tdata[15:0];
   assign w_mag    = !w_sample[15]         ? w_sample :
                     (w_sample == 16'h8000) ? 16'h7FFF : (~w_sample + 16'd1);
   assign w_mod    = (w_mag >= threshold_in);
   assign w_unused = ^s00_axis_tdata;

   assign w_outFree       = ~r_mValid | m00_axis_tready;
   assign w_sReady        = (r_state != FLUSH) & w_outFree;
   assign w_accept        = s00_axis_tvalid & w_sReady;
   assign s00_axis_tready = s00_axis_aresetn & w_sReady;

   assign w_inFirst   = (r_sampCnt < C_HALF);
   assign w_inSecond  = ~w_inFirst;
   assign w_modFirst  = w_inFirst & w_mod;
   assign w_modSecond = w_inSecond & w_mod;
   assign w_lastSamp  = (r_sampCnt == C_LAST_SAMP);
   assign w_cntFirst  = r_cntFirst + HCW'(w_modFirst);
   assign w_cntSecond = r_cntSecond + HCW'(w_modSecond);

   assign w_stepSampCnt   = w_lastSamp ? '0 : r_sampCnt + SCW'(1);
   assign w_stepCntFirst  = w_lastSamp ? '0 : w_cntFirst;
   assign w_stepCntSecond = w_lastSamp ? '0 : w_cntSecond;

   // A collision (both halves high) still decodes as a 1, only flagged.
   assign w_firstHigh  = (w_cntFirst > C_HIGH_THR);
   assign w_secondHigh = (w_cntSecond > C_HIGH_THR);
   assign w_isEof      = ~w_firstHigh & ~w_secondHigh;
   assign w_isColl     = w_firstHigh & w_secondHigh;
   assign w_bit        = w_firstHigh;

   assign w_byteRec = {r_coll | w_isColl, ~(^r_shift ^ w_bit), 1'b1, 4'd8, r_shift};
   assign w_partRec = {r_coll, 1'b0, 1'b0, r_bitCnt, r_shift};

   assign m00_axis_tvalid  = r_mValid;
   assign m00_axis_tdata   = C_M00_AXIS_TDATA_WIDTH'(r_mData);
   assign m00_axis_tlast   = r_mLast;
   assign m00_axis_tstrb   = {(C_M00_AXIS_TDATA_WIDTH/8){r_mValid}};
   assign frame_active_out = r_frameActive;

   always_comb begin
      w_nextState       = r_state;
      w_nextSampCnt     = r_sampCnt;
      w_nextCntFirst    = r_cntFirst;
      w_nextCntSecond   = r_cntSecond;
      w_nextShift       = r_shift;
      w_nextBitCnt      = r_bitCnt;
      w_nextColl        = r_coll;
      w_nextHoldValid   = r_holdValid;
      w_nextHoldRec     = r_holdRec;
      w_nextMValid      = r_mValid;
      w_nextMData       = r_mData;
      w_nextMLast       = r_mLast;
      w_nextFrameActive = r_frameActive;

      if (r_mValid && m00_axis_tready) begin
         w_nextMValid = 1'b0;
      end

      case (r_state)
         IDLE: begin
            if (w_accept && w_mod) begin
               w_nextState     = SOF;
               w_nextSampCnt   = SCW'(1);
               w_nextCntFirst  = HCW'(1);
               w_nextCntSecond = '0;
            end
         end

         SOF: begin
            if (w_accept) begin
               w_nextSampCnt   = w_stepSampCnt;
               w_nextCntFirst  = w_stepCntFirst;
               w_nextCntSecond = w_stepCntSecond;
               if (w_lastSamp) begin
                  if (w_firstHigh && !w_secondHigh) begin
                     w_nextState       = DATA;
                     w_nextFrameActive = 1'b1;
                     w_nextShift       = '0;
                     w_nextBitCnt      = '0;
                     w_nextColl        = 1'b0;
                     w_nextHoldValid   = 1'b0;
                  end else begin
                     w_nextState = IDLE;
                  end
               end
               if (s00_axis_tlast) begin
                  w_nextState       = IDLE;
                  w_nextFrameActive = 1'b0;
                  w_nextSampCnt     = '0;
                  w_nextCntFirst    = '0;
                  w_nextCntSecond   = '0;
               end
            end
         end

         DATA: begin
            if (w_accept) begin
               w_nextSampCnt   = w_stepSampCnt;
               w_nextCntFirst  = w_stepCntFirst;
               w_nextCntSecond = w_stepCntSecond;
               if (w_lastSamp) begin
                  if (w_isEof) begin
                     w_nextState = FLUSH;
                  end else if (r_bitCnt < 4'd8) begin
                     w_nextShift[r_bitCnt[2:0]] = w_bit;
                     w_nextBitCnt               = r_bitCnt + 4'd1;
                     w_nextColl                 = r_coll | w_isColl;
                  end else begin
                     // Accepting a sample guarantees the output slot is free this cycle.
                     if (r_holdValid) begin
                        w_nextMValid = 1'b1;
                        w_nextMData  = r_holdRec;
                        w_nextMLast  = 1'b0;
                     end
                     w_nextHoldRec   = w_byteRec;
                     w_nextHoldValid = 1'b1;
                     w_nextBitCnt    = '0;
                     w_nextShift     = '0;
                     w_nextColl      = 1'b0;
                  end
               end
               if (s00_axis_tlast) begin
                  w_nextState     = FLUSH;
                  w_nextSampCnt   = '0;
                  w_nextCntFirst  = '0;
                  w_nextCntSecond = '0;
               end
            end
         end

         FLUSH: begin
            if (w_outFree) begin
               if (r_holdValid) begin
                  w_nextMValid    = 1'b1;
                  w_nextMData     = r_holdRec;
                  w_nextMLast     = (r_bitCnt == 4'd0);
                  w_nextHoldValid = 1'b0;
               end else if (r_bitCnt != 4'd0) begin
                  w_nextMValid = 1'b1;
                  w_nextMData  = w_partRec;
                  w_nextMLast  = 1'b1;
                  w_nextBitCnt = '0;
               end else begin
                  w_nextState       = IDLE;
                  w_nextFrameActive = 1'b0;
                  w_nextShift       = '0;
                  w_nextColl        = 1'b0;
               end
            end
         end

         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         r_state       <= IDLE;
         r_sampCnt     <= '0;
         r_cntFirst    <= '0;
         r_cntSecond   <= '0;
         r_shift       <= '0;
         r_bitCnt      <= '0;
         r_coll        <= 1'b0;
         r_holdValid   <= 1'b0;
         r_holdRec     <= '0;
         r_mValid      <= 1'b0;
         r_mData       <= '0;
         r_mLast       <= 1'b0;
         r_frameActive <= 1'b0;
      end else begin
         r_state       <= w_nextState;
         r_sampCnt     <= w_nextSampCnt;
         r_cntFirst    <= w_nextCntFirst;
         r_cntSecond   <= w_nextCntSecond;
         r_shift       <= w_nextShift;
         r_bitCnt      <= w_nextBitCnt;
         r_coll        <= w_nextColl;
         r_holdValid   <= w_nextHoldValid;
         r_holdRec     <= w_nextHoldRec;
         r_mValid      <= w_nextMValid;
         r_mData       <= w_nextMData;
         r_mLast       <= w_nextMLast;
         r_frameActive <= w_nextFrameActive;
      end
   end

endmodule
